// File: rtl/score_pkg.sv
// Shared constants for the scoreboard: FINISH code, view layout and the
// seven-segment character set (segment order gfedcba).
package score_pkg;

    localparam logic [2:0] FINISH = 3'b101;

    // View numbering: CURR, then one view per table rank, then HITS and MISSES.
    localparam int VIEW_CURR       = 0;
    localparam int VIEW_HI_BASE    = 1;
    localparam int VIEW_HITS_OFS   = 1;
    localparam int VIEW_MISSES_OFS = 2;

    typedef enum logic [1:0] {
        VK_CURR,
        VK_HIGH,
        VK_HITS,
        VK_MISSES
    } view_kind_e;

    localparam logic [6:0] BLANK = 7'b0000000;

    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        if (d > 4'd9) begin
            return BLANK;
        end
        return SEG_TABLE[d];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle; the
// result register only changes when a conversion completes.
module bin2bcd_seq #(
    parameter int SCORE_W = 8,
    parameter int DIGITS  = 3
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0]  bin_sh;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] acc_adj;
    logic [4*DIGITS-1:0] acc_next;
    logic [CW-1:0]       cnt;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_next = {acc_adj[4*DIGITS-2:0], bin_sh[SCORE_W-1]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            bin_sh <= '0;
            acc    <= '0;
            bcd    <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy   <= 1'b1;
                    bin_sh <= bin;
                    acc    <= '0;
                    cnt    <= '0;
                end
            end else begin
                acc    <= acc_next;
                bin_sh <= {bin_sh[SCORE_W-2:0], 1'b0};
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(SCORE_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bcd  <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/sync_posedge.sv
// Two-flop synchroniser plus registered rising-edge detector; an input that is
// already high when reset is released must fall before it can produce a pulse.
module sync_posedge (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic pulse
);

    logic s1, s2, s3;
    logic [1:0] fill;
    logic armed;

    // NOTE: every flop here uses <= so all stages sample the previous cycle's
    // values; blocking assignments would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            fill  <= 2'b00;
            armed <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= d;
            s2    <= s1;
            s3    <= s2;
            fill  <= {fill[0], 1'b1};
            // s2 only reflects the real input once the chain has refilled.
            armed <= armed | (fill[1] & ~s2);
            pulse <= s2 & ~s3 & armed;
        end
    end

endmodule

// File: rtl/score_board_disp.sv
// End-of-game scoreboard: sorted high-score table updated once per FINISH
// entry, and a button-cycled seven-segment view of score, ranks, hits, misses.
module score_board_disp
    import score_pkg::*;
#(
    parameter int SCORE_W  = 8,
    parameter int NUM_HIGH = 4,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          score_tog,
    input  logic [2:0]                    mode,
    input  logic [SCORE_W-1:0]            score,
    input  logic [SCORE_W-1:0]            hits,
    input  logic [SCORE_W-1:0]            misses,
    output logic [7*DIGITS-1:0]           SS_disp,
    output logic                          red,
    output logic                          green,
    output logic [$clog2(NUM_HIGH+3)-1:0] view_rank,
    output logic                          new_record
);

    localparam int VW = $clog2(NUM_HIGH + 3);
    localparam int PW = (NUM_HIGH > 1) ? $clog2(NUM_HIGH) : 1;
    localparam logic [VW-1:0] V_LAST_HI = VW'(NUM_HIGH);
    localparam logic [VW-1:0] V_HITS    = VW'(NUM_HIGH + VIEW_HITS_OFS);
    localparam logic [VW-1:0] V_MISSES  = VW'(NUM_HIGH + VIEW_MISSES_OFS);

    logic tog_p;
    logic fin_p;
    logic [2:0] mode_q;

    logic [VW-1:0] view_q, view_d;
    view_kind_e    kind;
    logic [PW-1:0] hi_idx;

    logic [SCORE_W-1:0] tbl      [NUM_HIGH];
    logic [SCORE_W-1:0] tbl_next [NUM_HIGH];
    logic               ins_found;
    logic [PW-1:0]      ins_pos;

    logic [SCORE_W-1:0]  sel_val, cap_val, last_conv;
    logic                conv_start, conv_busy, conv_done;
    logic [4*DIGITS-1:0] bcd;
    logic                lead;
    logic [3:0]          digit;

    sync_posedge u_tog_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (score_tog),
        .pulse (tog_p)
    );

    assign fin_p = (mode == FINISH) && (mode_q != FINISH);

    // View FSM: state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            view_q <= VW'(VIEW_CURR);
        end else begin
            view_q <= view_d;
        end
    end

    // View FSM: next state.
    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a value held, which would otherwise infer a latch.
    always_comb begin
        view_d = view_q;
        if (tog_p) begin
            view_d = (view_q == V_MISSES) ? VW'(VIEW_CURR) : view_q + 1'b1;
        end
    end

    // View FSM: outputs (LEDs and the value routed to the converter).
    always_comb begin
        kind    = VK_MISSES;
        red     = 1'b1;
        green   = 1'b0;
        sel_val = misses;
        hi_idx  = PW'(view_q - VW'(VIEW_HI_BASE));
        if (view_q == VW'(VIEW_CURR)) begin
            kind = VK_CURR;
        end else if (view_q <= V_LAST_HI) begin
            kind = VK_HIGH;
        end else if (view_q == V_HITS) begin
            kind = VK_HITS;
        end
        case (kind)
            VK_CURR:   begin red = 1'b0; green = 1'b0; sel_val = score;       end
            VK_HIGH:   begin red = 1'b1; green = 1'b1; sel_val = tbl[hi_idx]; end
            VK_HITS:   begin red = 1'b0; green = 1'b1; sel_val = hits;        end
            default:   begin red = 1'b1; green = 1'b0; sel_val = misses;      end
        endcase
    end

    assign view_rank = view_q;

    // Lowest rank strictly beaten by the score; ties keep the older entry.
    always_comb begin
        ins_found = 1'b0;
        ins_pos   = '0;
        for (int i = NUM_HIGH - 1; i >= 0; i--) begin
            if (score > tbl[i]) begin
                ins_found = 1'b1;
                ins_pos   = PW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_HIGH; i++) begin
            tbl_next[i] = tbl[i];
        end
        if (fin_p && ins_found) begin
            for (int i = 1; i < NUM_HIGH; i++) begin
                if (i > int'(ins_pos)) begin
                    tbl_next[i] = tbl[i-1];
                end
            end
            for (int i = 0; i < NUM_HIGH; i++) begin
                if (i == int'(ins_pos)) begin
                    tbl_next[i] = score;
                end
            end
        end
    end

    // NOTE: the table is a handful of flops, not a RAM, so it is cleared by
    // reset like any other state; a RAM-backed table could not be.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q     <= '0;
            new_record <= 1'b0;
            for (int i = 0; i < NUM_HIGH; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            mode_q <= mode;
            for (int i = 0; i < NUM_HIGH; i++) begin
                tbl[i] <= tbl_next[i];
            end
            if (fin_p) begin
                new_record <= (score > tbl[0]);
            end else if (mode != FINISH) begin
                new_record <= 1'b0;
            end
        end
    end

    // Start a conversion whenever the shown value differs from the last one
    // converted; the done cycle is skipped so last_conv is current first.
    assign conv_start = !conv_busy && !conv_done && (sel_val != last_conv);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cap_val   <= '0;
            last_conv <= '0;
        end else begin
            if (conv_start) begin
                cap_val <= sel_val;
            end
            if (conv_done) begin
                last_conv <= cap_val;
            end
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bcd (
        .clk   (clk),
        .n_rst (n_rst),
        .start (conv_start),
        .bin   (sel_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        lead    = (BLANK_LZ != 0);
        digit   = '0;
        SS_disp = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            digit = bcd[4*d +: 4];
            if (lead && (digit == 4'd0) && (d != 0)) begin
                SS_disp[7*d +: 7] = BLANK;
            end else begin
                lead              = 1'b0;
                SS_disp[7*d +: 7] = bcd_to_seg(digit);
            end
        end
    end

endmodule

// File: tb/tb_score_board_disp.sv
// Directed bench for score_board_disp: reset state, table insertion order,
// view cycling with LEDs, display latency, glitch-free updates, mid-run reset.
module tb_score_board_disp;

    localparam int SCORE_W   = 8;
    localparam int CONV_WAIT = 2 * SCORE_W + 2;
    localparam logic [2:0] FIN = 3'b101;
    localparam logic [2:0] IDLE_MODE = 3'b000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        score_tog = 1'b0;
    logic [2:0]  mode = IDLE_MODE;
    logic [7:0]  score = '0;
    logic [7:0]  hits = '0;
    logic [7:0]  misses = '0;
    logic [20:0] SS_disp;
    logic        red, green, new_record;
    logic [2:0]  view_rank;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    score_board_disp #(
        .SCORE_W  (8),
        .NUM_HIGH (4),
        .DIGITS   (3),
        .BLANK_LZ (1)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .score_tog  (score_tog),
        .mode       (mode),
        .score      (score),
        .hits       (hits),
        .misses     (misses),
        .SS_disp    (SS_disp),
        .red        (red),
        .green      (green),
        .view_rank  (view_rank),
        .new_record (new_record)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    function automatic logic [20:0] disp(input int v);
        int d2, d1, d0;
        logic [6:0] hi, mid;
        d2  = v / 100;
        d1  = (v / 10) % 10;
        d0  = v % 10;
        hi  = (d2 == 0) ? 7'h00 : seg(d2);
        mid = (d2 == 0 && d1 == 0) ? 7'h00 : seg(d1);
        return {hi, mid, seg(d0)};
    endfunction

    // Press and hold; the view must still be old 3 edges later and new on the 4th.
    task automatic press(input logic [2:0] from, input logic [2:0] to);
        score_tog = 1'b1;
        cyc(3);
        check("view_before_pulse", view_rank, from);
        cyc(1);
        check("view_after_pulse", view_rank, to);
        score_tog = 1'b0;
        cyc(4);
    endtask

    task automatic view_step(input logic [2:0] from, input logic [2:0] to,
                             input logic [1:0] leds, input int val);
        press(from, to);
        check("leds", {red, green}, leds);
        cyc(CONV_WAIT);
        check("view_disp", SS_disp, disp(val));
    endtask

    task automatic game(input logic [7:0] s, input logic exp_nr);
        score = s;
        mode  = FIN;
        cyc(1);
        check("new_record", new_record, exp_nr);
        mode = IDLE_MODE;
        cyc(1);
        check("new_record_clear", new_record, 1'b0);
        cyc(2);
    endtask

    initial begin
        logic ok;

        // Reset state.
        cyc(2);
        n_rst = 1'b1;
        cyc(CONV_WAIT + 2);
        check("rst_disp", SS_disp, 21'h00003F);
        check("rst_view", view_rank, 3'd0);
        check("rst_leds", {red, green}, 2'b00);
        check("rst_new_record", new_record, 1'b0);

        // Every view reads zero after reset.
        view_step(3'd0, 3'd1, 2'b11, 0);
        view_step(3'd1, 3'd2, 2'b11, 0);
        view_step(3'd2, 3'd3, 2'b11, 0);
        view_step(3'd3, 3'd4, 2'b11, 0);
        view_step(3'd4, 3'd5, 2'b01, 0);
        view_step(3'd5, 3'd6, 2'b10, 0);
        view_step(3'd6, 3'd0, 2'b00, 0);

        // Games: table becomes 200, 200, 120, 50.
        game(8'd50,  1'b1);
        game(8'd200, 1'b1);
        game(8'd120, 1'b0);
        game(8'd200, 1'b0);
        game(8'd10,  1'b0);

        // FINISH held for 100 cycles: one insertion only.
        score = 8'd255;
        mode  = FIN;
        cyc(1);
        check("hold_new_record", new_record, 1'b1);
        cyc(99);
        check("hold_new_record_kept", new_record, 1'b1);
        mode = IDLE_MODE;
        cyc(1);
        check("hold_new_record_clear", new_record, 1'b0);

        // CURR view latency for 0 -> 255.
        score = 8'd0;
        cyc(CONV_WAIT + 2);
        check("curr_zero", SS_disp, disp(0));
        score = 8'd255;
        cyc(CONV_WAIT);
        check("curr_255", SS_disp, disp(255));

        // Walk all views: table = 255, 200, 200, 120.
        hits   = 8'd37;
        misses = 8'd4;
        view_step(3'd0, 3'd1, 2'b11, 255);
        view_step(3'd1, 3'd2, 2'b11, 200);
        view_step(3'd2, 3'd3, 2'b11, 200);
        view_step(3'd3, 3'd4, 2'b11, 120);
        view_step(3'd4, 3'd5, 2'b01, 37);
        view_step(3'd5, 3'd6, 2'b10, 4);
        view_step(3'd6, 3'd0, 2'b00, 255);

        // Rapid source changes never show a partial value.
        score = 8'd7;
        cyc(1);
        score = 8'd8;
        cyc(1);
        score = 8'd9;
        for (int i = 0; i < 2 * CONV_WAIT + 4; i++) begin
            cyc(1);
            ok = (SS_disp == disp(255)) || (SS_disp == disp(7)) ||
                 (SS_disp == disp(8)) || (SS_disp == disp(9));
            check("no_mixed_digits", ok, 1'b1);
        end
        check("settle_9", SS_disp, disp(9));

        // Reset mid-conversion with the button held.
        score = 8'd123;
        cyc(3);
        score_tog = 1'b1;
        cyc(4);
        check("pre_reset_view", view_rank, 3'd1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_disp", SS_disp, 21'h00003F);
        check("mid_rst_view", view_rank, 3'd0);
        check("mid_rst_leds", {red, green}, 2'b00);
        check("mid_rst_new_record", new_record, 1'b0);
        cyc(2);
        n_rst = 1'b1;
        cyc(10);
        check("held_button_no_advance", view_rank, 3'd0);
        cyc(CONV_WAIT);
        check("post_rst_disp", SS_disp, disp(123));
        check("held_button_still_curr", view_rank, 3'd0);
        score_tog = 1'b0;
        cyc(4);
        view_step(3'd0, 3'd1, 2'b11, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
